// File: rtl/sys_input_conditioner.sv
// Slow asynchronous input conditioner: per channel two-flop synchroniser, debouncer,
// edge pulses, sticky clearable event flag and LED pulse stretcher.
// Stretcher logic is compiled in only when SYS_INPUT_CONDITIONER_STRETCH_EN is defined.
module sys_input_conditioner #(
    parameter int                NUM_CH    = 4,
    parameter int                DEB_LEN   = 16,
    parameter logic [NUM_CH-1:0] RESET_VAL = {NUM_CH{1'b1}},
    parameter int                STRETCH_W = 24
) (
    input  logic              clk27,
    input  logic              reset,
    input  logic [NUM_CH-1:0] async_i,
    input  logic [NUM_CH-1:0] event_clr_i,
    output logic [NUM_CH-1:0] sync_o,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] event_o,
    output logic [NUM_CH-1:0] stretch_o
);

    localparam int              CNT_W    = $clog2(DEB_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LEN - 1);

    logic [NUM_CH-1:0] s1_q, s2_q;
    logic [NUM_CH-1:0] level_q, level_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;
    logic [NUM_CH-1:0] event_q, event_d;
    logic [NUM_CH-1:0] update;

    // The level only updates on a mismatch, so toggling equals taking the synced value.
    assign level_d = level_q ^ update;
    assign rise_d  = update & s2_q;
    assign fall_d  = update & ~s2_q;
    assign event_d = (event_q & ~event_clr_i) | update;

    always_ff @(posedge clk27) begin
        if (reset) begin
            s1_q    <= RESET_VAL;
            s2_q    <= RESET_VAL;
            level_q <= RESET_VAL;
            rise_q  <= '0;
            fall_q  <= '0;
            event_q <= '0;
        end else begin
            s1_q    <= async_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            event_q <= event_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             mismatch;

            assign mismatch   = s2_q[gi] ^ level_q[gi];
            assign update[gi] = mismatch && (cnt_q == CNT_LAST);
            // Any sample agreeing with the current level restarts the count.
            assign cnt_d      = (mismatch && !update[gi]) ? cnt_q + 1'b1 : '0;

            always_ff @(posedge clk27) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

`ifdef SYS_INPUT_CONDITIONER_STRETCH_EN
            logic [STRETCH_W-1:0] scnt_q, scnt_d;

            // Retrigger simply reloads; the counter saturates at zero.
            always_comb begin
                scnt_d = scnt_q;
                if (rise_d[gi]) begin
                    scnt_d = '1;
                end else if (scnt_q != '0) begin
                    scnt_d = scnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk27) begin
                if (reset) begin
                    scnt_q <= '0;
                end else begin
                    scnt_q <= scnt_d;
                end
            end

            assign stretch_o[gi] = (scnt_q != '0);
`else
            assign stretch_o[gi] = 1'b0;
`endif
        end
    endgenerate

    assign sync_o  = s2_q;
    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign event_o = event_q;

endmodule

// File: tb/tb_sys_input_conditioner.sv
// Directed bench for sys_input_conditioner (NUM_CH=2, DEB_LEN=4, STRETCH_W=4).
// Stretch expectations follow whether SYS_INPUT_CONDITIONER_STRETCH_EN is defined.
module tb_sys_input_conditioner;

    localparam int         NUM_CH    = 2;
    localparam int         DEB_LEN   = 4;
    localparam int         STRETCH_W = 4;
    localparam logic [1:0] RESET_VAL = 2'b11;
`ifdef SYS_INPUT_CONDITIONER_STRETCH_EN
    localparam bit STRETCH_EN = 1'b1;
`else
    localparam bit STRETCH_EN = 1'b0;
`endif

    logic       clk27 = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] async_i = 2'b00;
    logic [1:0] event_clr_i = 2'b00;
    logic [1:0] sync_o, level_o, rise_o, fall_o, event_o, stretch_o;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk27 = ~clk27;

    sys_input_conditioner #(
        .NUM_CH   (NUM_CH),
        .DEB_LEN  (DEB_LEN),
        .RESET_VAL(RESET_VAL),
        .STRETCH_W(STRETCH_W)
    ) dut (
        .clk27      (clk27),
        .reset      (reset),
        .async_i    (async_i),
        .event_clr_i(event_clr_i),
        .sync_o     (sync_o),
        .level_o    (level_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .event_o    (event_o),
        .stretch_o  (stretch_o)
    );

    task automatic tick();
        @(posedge clk27);
        #1;
    endtask

    // Drive both channels idle-high long enough for pulses and stretch to finish, then clear events.
    task automatic go_idle();
        async_i = 2'b11;
        repeat (30) tick();
        event_clr_i = 2'b11;
        tick();
        event_clr_i = 2'b00;
    endtask

    task automatic test_reset();
        int f0_cnt, f1_cnt, f0_at, f1_at, r_cnt;
        f0_cnt = 0; f1_cnt = 0; f0_at = 0; f1_at = 0; r_cnt = 0;
        reset = 1'b1;
        async_i = 2'b00;
        event_clr_i = 2'b00;
        repeat (3) tick();
        n_cmp++; if (level_o !== 2'b11) begin n_mis++; $display("FAIL reset_level: got %b want 11", level_o); end
        n_cmp++; if (sync_o !== 2'b11) begin n_mis++; $display("FAIL reset_sync: got %b want 11", sync_o); end
        n_cmp++; if ({rise_o, fall_o, event_o, stretch_o} !== 8'h00) begin
            n_mis++; $display("FAIL reset_outs: rise=%b fall=%b event=%b stretch=%b want all 0", rise_o, fall_o, event_o, stretch_o);
        end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (fall_o[0] === 1'b1) begin f0_cnt++; f0_at = k; end
            if (fall_o[1] === 1'b1) begin f1_cnt++; f1_at = k; end
            if (rise_o !== 2'b00) r_cnt++;
        end
        n_cmp++; if (f0_cnt !== 1 || f0_at !== 6) begin n_mis++; $display("FAIL reset_fall0: count %0d at %0d want 1 at 6", f0_cnt, f0_at); end
        n_cmp++; if (f1_cnt !== 1 || f1_at !== 6) begin n_mis++; $display("FAIL reset_fall1: count %0d at %0d want 1 at 6", f1_cnt, f1_at); end
        n_cmp++; if (r_cnt !== 0) begin n_mis++; $display("FAIL reset_rise: %0d rise cycles want 0", r_cnt); end
        n_cmp++; if (event_o !== 2'b11 || level_o !== 2'b00) begin
            n_mis++; $display("FAIL reset_after: event=%b level=%b want 11/00", event_o, level_o);
        end
        $display("tb: test_reset done");
        go_idle();
    endtask

    task automatic test_glitch();
        int low_cnt, lvl_drop, f_cnt;
        low_cnt = 0; lvl_drop = 0; f_cnt = 0;
        async_i = 2'b10;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (sync_o[0] === 1'b0) low_cnt++;
            if (level_o[0] !== 1'b1) lvl_drop++;
            if (fall_o[0] !== 1'b0) f_cnt++;
            if (k == 3) async_i = 2'b11;
        end
        n_cmp++; if (low_cnt !== 3) begin n_mis++; $display("FAIL glitch_sync: low %0d cycles want 3", low_cnt); end
        n_cmp++; if (lvl_drop !== 0) begin n_mis++; $display("FAIL glitch_level: dropped %0d cycles want 0", lvl_drop); end
        n_cmp++; if (f_cnt !== 0) begin n_mis++; $display("FAIL glitch_fall: %0d pulses want 0", f_cnt); end
        n_cmp++; if (event_o[0] !== 1'b0) begin n_mis++; $display("FAIL glitch_event: got %b want 0", event_o[0]); end
        $display("tb: test_glitch done");
    endtask

    task automatic test_press_release();
        int f_cnt, f_at, r_cnt, r_at, s_cnt, s_first, other;
        f_cnt = 0; f_at = 0; r_cnt = 0; r_at = 0; s_cnt = 0; s_first = 0; other = 0;
        async_i = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (fall_o[0] === 1'b1) begin f_cnt++; f_at = k; end
            if (rise_o[1] !== 1'b0 || fall_o[1] !== 1'b0) other++;
        end
        n_cmp++; if (f_cnt !== 1 || f_at !== 6) begin n_mis++; $display("FAIL press_fall: count %0d at %0d want 1 at 6", f_cnt, f_at); end
        n_cmp++; if (level_o !== 2'b10) begin n_mis++; $display("FAIL press_level: got %b want 10", level_o); end
        async_i = 2'b11;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (rise_o[0] === 1'b1) begin r_cnt++; r_at = k; end
            if (stretch_o[0] === 1'b1) begin
                if (s_cnt == 0) s_first = k;
                s_cnt++;
            end
            if (rise_o[1] !== 1'b0 || fall_o[1] !== 1'b0) other++;
        end
        n_cmp++; if (r_cnt !== 1 || r_at !== 6) begin n_mis++; $display("FAIL release_rise: count %0d at %0d want 1 at 6", r_cnt, r_at); end
        n_cmp++; if (s_cnt !== (STRETCH_EN ? 15 : 0)) begin n_mis++; $display("FAIL stretch_len: got %0d want %0d", s_cnt, STRETCH_EN ? 15 : 0); end
        n_cmp++; if (s_first !== (STRETCH_EN ? 6 : 0)) begin n_mis++; $display("FAIL stretch_start: got %0d want %0d", s_first, STRETCH_EN ? 6 : 0); end
        n_cmp++; if (other !== 0) begin n_mis++; $display("FAIL ch1_quiet: %0d pulse cycles want 0", other); end
        n_cmp++; if (event_o !== 2'b01) begin n_mis++; $display("FAIL press_event: got %b want 01", event_o); end
        $display("tb: test_press_release done");
        go_idle();
    endtask

    task automatic test_event_collision();
        async_i = 2'b01;
        repeat (5) tick();
        n_cmp++; if (event_o[1] !== 1'b0 || fall_o[1] !== 1'b0) begin
            n_mis++; $display("FAIL coll_pre: event=%b fall=%b want 0/0", event_o[1], fall_o[1]);
        end
        event_clr_i = 2'b10;
        tick();
        n_cmp++; if (fall_o[1] !== 1'b1) begin n_mis++; $display("FAIL coll_fall: got %b want 1", fall_o[1]); end
        n_cmp++; if (event_o[1] !== 1'b1) begin n_mis++; $display("FAIL coll_set_wins: got %b want 1", event_o[1]); end
        tick();
        n_cmp++; if (event_o[1] !== 1'b0) begin n_mis++; $display("FAIL coll_clear: got %b want 0", event_o[1]); end
        event_clr_i = 2'b00;
        $display("tb: test_event_collision done");
        go_idle();
    endtask

    task automatic test_retrigger();
        int r_cnt, r_last, s_cnt, s_first, s_last;
        r_cnt = 0; r_last = 0; s_cnt = 0; s_first = 0; s_last = 0;
        async_i = 2'b10;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (rise_o[0] === 1'b1) begin r_cnt++; r_last = k; end
            if (stretch_o[0] === 1'b1) begin
                if (s_cnt == 0) s_first = k;
                s_cnt++;
                s_last = k;
            end
            if (k == 6)  async_i = 2'b11;
            if (k == 12) async_i = 2'b10;
            if (k == 17) async_i = 2'b11;
        end
        n_cmp++; if (r_cnt !== 2 || r_last !== 23) begin n_mis++; $display("FAIL retrig_rise: count %0d last %0d want 2 last 23", r_cnt, r_last); end
        n_cmp++; if (s_cnt !== (STRETCH_EN ? 26 : 0)) begin n_mis++; $display("FAIL retrig_len: got %0d want %0d", s_cnt, STRETCH_EN ? 26 : 0); end
        n_cmp++; if (s_first !== (STRETCH_EN ? 12 : 0) || s_last !== (STRETCH_EN ? 37 : 0)) begin
            n_mis++; $display("FAIL retrig_span: %0d..%0d want %0d..%0d", s_first, s_last, STRETCH_EN ? 12 : 0, STRETCH_EN ? 37 : 0);
        end
        $display("tb: test_retrigger done");
        go_idle();
    endtask

    task automatic test_reset_mid();
        int f_cnt, f_at;
        f_cnt = 0; f_at = 0;
        async_i = 2'b10;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 6)  async_i = 2'b11;
            if (k == 14) async_i = 2'b10;
        end
        n_cmp++; if (stretch_o[0] !== STRETCH_EN) begin n_mis++; $display("FAIL mid_pre_stretch: got %b want %b", stretch_o[0], STRETCH_EN); end
        reset = 1'b1;
        tick();
        n_cmp++; if (level_o !== RESET_VAL || sync_o !== RESET_VAL) begin
            n_mis++; $display("FAIL mid_level: level=%b sync=%b want 11/11", level_o, sync_o);
        end
        n_cmp++; if ({rise_o, fall_o, event_o, stretch_o} !== 8'h00) begin
            n_mis++; $display("FAIL mid_outs: rise=%b fall=%b event=%b stretch=%b want all 0", rise_o, fall_o, event_o, stretch_o);
        end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (fall_o[0] === 1'b1) begin f_cnt++; f_at = k; end
        end
        n_cmp++; if (f_cnt !== 1 || f_at !== 6) begin n_mis++; $display("FAIL mid_restart: count %0d at %0d want 1 at 6", f_cnt, f_at); end
        $display("tb: test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press_release();
        test_event_collision();
        test_retrigger();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
